// File: rtl/ec2_pkg.sv
// Shared constants for the ec2 display path.
//   DIGITS     : number of multiplexed 7-segment digits
//   SEG_0..F   : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK  : all segments off
package ec2_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-7-segment decoder.
//   hex : 4-bit nibble
//   seg : active-low segments {g,f,e,d,c,b,a}
module hex7seg
    import ec2_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ec2_display.sv
// Four-digit multiplexed hex display for the ec2 CPU result word.
// Data/Halt are snapshotted once per frame into shadow registers so a
// frame never shows a torn word; while the shadowed Halt is set the
// decimal points blink with a half-period of BLINK_DIV frames.
//   Clock  : system clock, rising edge
//   Reset  : asynchronous active-low reset
//   Data   : 16-bit word to display
//   Halt   : CPU halted flag
//   An     : digit enables, active-low, An[0] = rightmost
//   Seg    : segments {g,f,e,d,c,b,a}, active-low
//   Dp     : decimal point, active-low
//   Frame  : one-cycle pulse in the snapshot cycle
module ec2_display
    import ec2_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64,
    parameter int LZ_BLANK  = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       Data,
    input  logic              Halt,
    output logic [DIGITS-1:0] An,
    output logic [6:0]        Seg,
    output logic              Dp,
    output logic              Frame
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] SCAN_TC  = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_data;
    logic          sh_halt;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic          tc;
    logic          snap;
    logic [3:0]    nib;
    logic [15:0]   upper;
    logic          blank;
    logic [6:0]    glyph;
    logic [DIGITS-1:0] an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    assign tc    = (scan_cnt == SCAN_TC);
    // scan_cnt is 0 throughout reset, so no snapshot can leak out of it
    assign snap  = tc && (idx == 2'd3);
    assign Frame = snap;

    always_comb begin
        nib     = sh_data[{idx, 2'b00} +: 4];
        // nibbles idx..3 of the shadow word; all zero means a leading zero
        upper   = sh_data >> {idx, 2'b00};
        blank   = (LZ_BLANK != 0) && (idx != 2'd0) && (upper == 16'h0000);
        an_nxt  = ~(DIGITS'(1) << idx);
        seg_nxt = blank ? SEG_BLANK : glyph;
        dp_nxt  = ~(sh_halt & phase);
    end

    hex7seg u_hex7seg (
        .hex (nib),
        .seg (glyph)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (tc) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sh_data <= 16'h0000;
            sh_halt <= 1'b0;
        end else if (snap) begin
            sh_data <= Data;
            sh_halt <= Halt;
        end
    end

    // Blink state counts only frames already shown as halted, so a
    // freshly captured Halt always begins with the phase at 0.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!sh_halt) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (snap) begin
            if (blink_cnt == BLINK_TC) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            An  <= '1;
            Seg <= SEG_BLANK;
            Dp  <= 1'b1;
        end else begin
            An  <= an_nxt;
            Seg <= seg_nxt;
            Dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_ec2_display.sv
module tb_ec2_display;

    localparam int SD = 4;
    localparam int BD = 2;
    localparam int FR = 4 * SD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data  = 16'h0000;
    logic        halt  = 1'b0;

    logic [3:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       dp1, dp0, fr1, fr0;

    always #5 clk = ~clk;

    ec2_display #(.SCAN_DIV(SD), .BLINK_DIV(BD), .LZ_BLANK(1)) dut (
        .Clock (clk), .Reset (rst_n), .Data (data), .Halt (halt),
        .An (an1), .Seg (seg1), .Dp (dp1), .Frame (fr1)
    );

    ec2_display #(.SCAN_DIV(SD), .BLINK_DIV(BD), .LZ_BLANK(0)) dut_nolz (
        .Clock (clk), .Reset (rst_n), .Data (data), .Halt (halt),
        .An (an0), .Seg (seg0), .Dp (dp0), .Frame (fr0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: time counted in clocks since reset release
    int          n       = 0;
    int          m_idx   = 0;
    int          hcount  = 0;
    logic [15:0] m_data  = 16'h0000;
    logic        m_halt  = 1'b0;
    logic [3:0]  e_an    = 4'hF;
    logic [6:0]  e_seg1  = 7'h7F;
    logic [6:0]  e_seg0  = 7'h7F;
    logic        e_dp    = 1'b1;
    int          frames_dut = 0;
    int          frames_exp = 0;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input logic [15:0] w, input int i, input bit lz);
        int rest;
        rest = int'(w) >> (4 * i);
        if (lz && i > 0 && rest == 0) return 7'b1111111;
        return glyph(rest % 16);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_data = 16'h0000; m_halt = 1'b0; hcount = 0;
            e_an = 4'hF; e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1;
        end else begin
            // outputs after this edge show the digit of the cycle just ended
            m_idx  = (n / SD) % 4;
            e_an   = 4'hF;
            e_an[m_idx] = 1'b0;
            e_seg1 = digit_seg(m_data, m_idx, 1'b1);
            e_seg0 = digit_seg(m_data, m_idx, 1'b0);
            e_dp   = !(m_halt && ((hcount / BD) % 2 == 1));
            if (n % FR == FR - 1) begin
                hcount = m_halt ? hcount + 1 : 0;
                m_data = data;
                m_halt = halt;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        logic e_fr;
        e_fr = rst_n && (n % FR == FR - 1);
        chk("an_lz1",    16'(an1),  16'(e_an));
        chk("an_lz0",    16'(an0),  16'(e_an));
        chk("seg_lz1",   16'(seg1), 16'(e_seg1));
        chk("seg_lz0",   16'(seg0), 16'(e_seg0));
        chk("dp_lz1",    16'(dp1),  16'(e_dp));
        chk("dp_lz0",    16'(dp0),  16'(e_dp));
        chk("frame_lz1", 16'(fr1),  16'(e_fr));
        chk("frame_lz0", 16'(fr0),  16'(e_fr));
        if (fr1) frames_dut++;
        if (e_fr) frames_exp++;
    end

    task automatic drive(input logic [15:0] d, input logic h);
        @(negedge clk);
        #1;
        data = d;
        halt = h;
    endtask

    task automatic run(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic reset_pulse(input int k);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (k) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < FR && (n % FR) != p; i++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an",  16'(an1),  16'h000F);
        chk("rst_seg", 16'(seg1), 16'h007F);
        chk("rst_dp",  16'(dp1),  16'h0001);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first_an",  16'(an1),  16'h000E);
        chk("first_seg", 16'(seg1), 16'h0040);
        run(20);

        drive(16'h00A1, 1'b0);
        run(3 * FR);

        drive(16'h1234, 1'b0);
        run(2 * FR);
        wait_pos(SD + 1);
        #1 data = 16'hFFFF;
        run(3 * FR);

        drive(16'h0F00, 1'b1);
        run(12 * FR);
        drive(16'h0F00, 1'b0);
        run(3 * FR);

        drive(16'h0042, 1'b1);
        run(2 * FR);
        wait_pos(2 * SD + 1);
        reset_pulse(2);
        run(3 * FR);

        for (int it = 0; it < 150; it++) begin
            logic [15:0] w;
            int r;
            r = $urandom_range(0, 15);
            w = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if (r == 0) begin
                reset_pulse($urandom_range(1, 3));
            end else if (r < 4) begin
                wait_pos(FR - 1);
                #1 data = w;
                halt = ~halt;
            end else begin
                drive(w, (r < 10) ? halt : ~halt);
            end
            run($urandom_range(1, 30));
        end

        chk("frame_count", 16'(frames_dut), 16'(frames_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ec2_display.md
EC2_DISPLAY -- requirements
Module: ec2_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clocks each digit is driven; legal range >= 2.
REQ-002 Parameter BLINK_DIV, default 64: frames per Halt blink half-period; legal range >= 1.
REQ-003 Parameter LZ_BLANK, default 1: 1 = blank leading zero digits.
REQ-004 Clock  in  1  single system clock, rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Data  in  16  CPU result word driven by the processor top's Output port.
REQ-007 Halt  in  1  CPU halted flag.
REQ-008 An  out  4  digit enables, active-low; An[0] = rightmost digit.
REQ-009 Seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Dp  out  1  decimal point, active-low.
REQ-011 Frame  out  1  one-cycle pulse on each frame snapshot.

Function
REQ-012 Scan counter SHALL count 0..SCAN_DIV-1 and wrap. Digit index (2 bits) SHALL advance 0->1->2->3->0 on each terminal count.
REQ-013 A frame SHALL be 4*SCAN_DIV clocks. A snapshot SHALL occur on the terminal count while the index is 3.
REQ-014 On a snapshot, the shadow registers SHALL load Data and Halt, and Frame SHALL be 1 for that same cycle only.
REQ-015 The display SHALL show only shadow values. Data changes mid-frame SHALL NOT appear until the next snapshot (tear-free); worst-case latency is one frame + 1 clock.
REQ-016 Nibble select: digit i SHALL show shadow[4i+3:4i].
REQ-017 Hex decode SHALL use the full 0-F glyph set; 0 = 1000000, 1 = 1111001, A = 0001000, F = 0001110.
REQ-018 When LZ_BLANK=1, digit i (i = 1..3) SHALL show Seg = 1111111 if nibbles i..3 of the shadow are all zero. Digit 0 SHALL never blank.
REQ-019 An, Seg and Dp SHALL be registered and reflect the index of the previous cycle (1-clock lag). Exactly one An bit SHALL be low at any time after the first post-reset clock.
REQ-020 Blink counter behaviour:
- SHALL count snapshots while shadow Halt = 1, and toggle the blink phase every BLINK_DIV snapshots.
- SHALL clear itself and its phase while shadow Halt = 0.
REQ-021 Dp SHALL be 0 on every digit when shadow Halt = 1 and phase = 1; otherwise Dp SHALL be 1.
REQ-022 Halt deasserting mid-frame SHALL take effect only at the next snapshot.
REQ-023 Halt rising at the snapshot cycle SHALL be captured in that snapshot; the phase starts at 0.

Reset
REQ-024 While Reset = 0, all state SHALL clear asynchronously: scan counter 0, index 0, shadow Data 0, shadow Halt 0, blink counter 0, phase 0.
REQ-025 While Reset = 0, outputs SHALL be An = 1111, Seg = 1111111, Dp = 1, Frame = 0.
REQ-026 Release from reset SHALL be synchronous to Clock. The first clock after release SHALL drive An = 1110 with digit 0 showing 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame. No snapshot or Frame pulse SHALL be emitted for the aborted frame.

Structure
REQ-028 Segment glyph constants (0-F, SEG_BLANK) and the DIGITS = 4 constant SHALL reside in a shared package (ec2_pkg).
REQ-029 Hex-to-segment decode SHALL be a combinational sub-module, hex7seg (4-bit in, 7-bit active-low out), instantiated once on the selected nibble.

Verification (SCAN_DIV=4, BLINK_DIV=2 unless stated)
REQ-030 Hold Reset=0 for 3 clocks, then release with Data=0x0000 -> outputs at reset values during reset; next clock An=1110, Seg=1000000; An cycles 1110,1101,1011,0111 every 4 clocks.
REQ-031 Data=0x00A1, LZ_BLANK=1 -> after the next Frame: digit0 1111001, digit1 0001000, digits 2-3 1111111. With LZ_BLANK=0, digits 2-3 show 1000000.
REQ-032 Data changes 0x1234 -> 0xFFFF while the index is 1 -> digits keep showing 0x1234 until Frame, then all digits show 0001110.
REQ-033 Halt=1 held -> after the next Frame: Dp=1 for 2 frames, then Dp=0 on all digits for 2 frames, repeating. Halt=0 -> Dp=1 from the next snapshot; the phase is cleared.
REQ-034 Reset pulsed low at index 2 of a frame -> no Frame pulse for that frame. After release, the shadow is 0 and the first Frame appears 16 clocks later.
